// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and access sequencer for the processor's single shared
//   memory port. Three requesters (0 = fetch, 1 = load/store, 2 = vector DMA)
//   compete for the port. The winner's index drives the 2-bit select of the
//   3:1 address/data muxes (2'b11 = nobody, muxes output zero). Each access is
//   started with a one-cycle pulse, completed by the memory's done pulse or
//   aborted by a watchdog, and closed with a one-cycle ack to the winner.
//
// Ports
//   i_clk        single clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_req        i_req[i]=1: requester i wants the port, held until o_ack[i]
//   i_mem_done   one-cycle pulse from memory: current access complete
//   o_mux_sel    select for the shared 3:1 muxes, 2'b11 when no grant
//   o_mem_start  one-cycle pulse: access begins, o_mux_sel valid
//   o_ack        one-cycle pulse to the granted requester at completion/abort
//   o_timeout    one-cycle pulse, coincident with o_ack, when access aborted
//   o_busy       high while an access is in progress
module mem_port_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_mem_done,
    output logic [1:0]      o_mux_sel,
    output logic            o_mem_start,
    output logic [NREQ-1:0] o_ack,
    output logic            o_timeout,
    output logic            o_busy
);

    localparam int                CNT_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit                WATCHDOG_ON = (TIMEOUT != 0);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mux_sel;
    logic              r_mem_start;
    logic [NREQ-1:0]   r_ack;
    logic              r_timeout;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_last;

    state_t            w_state_next;
    logic [1:0]        w_mux_sel_next;
    logic              w_mem_start_next;
    logic [NREQ-1:0]   w_ack_next;
    logic              w_timeout_next;
    logic              w_busy_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [1:0]        w_last_next;
    logic [1:0]        w_grant;
    logic              w_grant_valid;
    logic [NREQ-1:0]   w_ack_onehot;
    logic              w_expire;

    // Round-robin pick: search starts one past the last requester served,
    // so the most recently served requester has the lowest priority.
    always_comb begin
        w_grant       = 2'd0;
        w_grant_valid = |i_req;
        case (r_last)
            2'd0: begin
                if      (i_req[1]) w_grant = 2'd1;
                else if (i_req[2]) w_grant = 2'd2;
                else               w_grant = 2'd0;
            end
            2'd1: begin
                if      (i_req[2]) w_grant = 2'd2;
                else if (i_req[0]) w_grant = 2'd0;
                else               w_grant = 2'd1;
            end
            default: begin
                if      (i_req[0]) w_grant = 2'd0;
                else if (i_req[1]) w_grant = 2'd1;
                else               w_grant = 2'd2;
            end
        endcase
    end

    // The held mux select identifies the current owner, so it also
    // tells us which ack line to pulse at the end of the access.
    always_comb begin
        w_ack_onehot = '0;
        case (r_mux_sel)
            2'd0:    w_ack_onehot = 3'b001;
            2'd1:    w_ack_onehot = 3'b010;
            2'd2:    w_ack_onehot = 3'b100;
            default: w_ack_onehot = '0;
        endcase
        w_expire = WATCHDOG_ON && (r_cnt == CNT_LAST);
    end

    // State register plus every registered output. Reset wins over
    // everything, including an access in flight, which is dropped silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_mux_sel   <= 2'b11;
            r_mem_start <= 1'b0;
            r_ack       <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 2'd2;
        end else begin
            r_state     <= w_state_next;
            r_mux_sel   <= w_mux_sel_next;
            r_mem_start <= w_mem_start_next;
            r_ack       <= w_ack_next;
            r_timeout   <= w_timeout_next;
            r_busy      <= w_busy_next;
            r_cnt       <= w_cnt_next;
            r_last      <= w_last_next;
        end
    end

    // Next state: leave IDLE on any request, leave BUSY on done or watchdog.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_valid)         w_state_next = ST_BUSY;
            ST_BUSY: if (i_mem_done || w_expire) w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs. A done pulse takes priority
    // over the watchdog firing in the same cycle. Request changes during
    // BUSY are not looked at, so the select stays frozen for the access.
    always_comb begin
        w_mux_sel_next   = 2'b11;
        w_mem_start_next = 1'b0;
        w_ack_next       = '0;
        w_timeout_next   = 1'b0;
        w_busy_next      = 1'b0;
        w_cnt_next       = r_cnt;
        w_last_next      = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_mux_sel_next   = w_grant;
                    w_mem_start_next = 1'b1;
                    w_busy_next      = 1'b1;
                    w_cnt_next       = '0;
                end
            end
            ST_BUSY: begin
                if (i_mem_done) begin
                    w_ack_next  = w_ack_onehot;
                    w_last_next = r_mux_sel;
                end else if (w_expire) begin
                    w_ack_next     = w_ack_onehot;
                    w_last_next    = r_mux_sel;
                    w_timeout_next = 1'b1;
                end else begin
                    w_mux_sel_next = r_mux_sel;
                    w_busy_next    = 1'b1;
                    w_cnt_next     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_mux_sel   = r_mux_sel;
    assign o_mem_start = r_mem_start;
    assign o_ack       = r_ack;
    assign o_timeout   = r_timeout;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: directed reset, rotation, skip,
//   watchdog, done/watchdog tie and mid-access reset scenarios, followed by
//   randomized traffic checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [2:0] i_req;
    logic       i_mem_done;
    logic [1:0] o_mux_sel;
    logic       o_mem_start;
    logic [2:0] o_ack;
    logic       o_timeout;
    logic       o_busy;

    int         errors = 0;
    int         checks = 0;
    int         mLast;
    logic [2:0] reqDrive;

    mem_port_arbiter #(.NREQ(3), .TIMEOUT(TMO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_mem_done  (i_mem_done),
        .o_mux_sel   (o_mux_sel),
        .o_mem_start (o_mem_start),
        .o_ack       (o_ack),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 i_clk = ~i_clk;

    // Reference round-robin rule: first requesting index after the last served one.
    function automatic int modelGrant(input logic [2:0] r, input int last);
        int idx;
        for (int k = 1; k <= 3; k++) begin
            idx = (last + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic done);
        i_req      = r;
        i_mem_done = done;
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s.%s got=%0d want=%0d", tag, what, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input int eSel, input int eStart,
                               input int eAck, input int eTo, input int eBusy);
        chk(tag, "mux_sel",   {30'd0, o_mux_sel},   eSel);
        chk(tag, "mem_start", {31'd0, o_mem_start}, eStart);
        chk(tag, "ack",       {29'd0, o_ack},       eAck);
        chk(tag, "timeout",   {31'd0, o_timeout},   eTo);
        chk(tag, "busy",      {31'd0, o_busy},      eBusy);
    endtask

    // One complete access, entered in an IDLE cycle with reqDrive already on i_req.
    // expG >= 0 forces the expected winner, otherwise the model picks it.
    // d is the BUSY cycle in which mem_done pulses (beyond TMO = never).
    // nextReq < 0 drops the winner's request and randomly raises new ones.
    task automatic runAccess(input string tag, input int expG, input int d, input int nextReq);
        int g;
        int k;
        int timedOut;
        g = (expG >= 0) ? expG : modelGrant(reqDrive, mLast);
        tick();
        checkOutput({tag, "-grant"}, g, 1, 0, 0, 1);
        for (k = 1; k <= TMO; k++) begin
            if (expG < 0 && $urandom_range(0, 3) == 0)
                reqDrive = reqDrive | 3'($urandom_range(0, 7));
            applyStimulus(reqDrive, k == d);
            tick();
            if (k == d || k == TMO) break;
            checkOutput({tag, "-busy"}, g, 0, 0, 0, 1);
        end
        timedOut = (k != d) ? 1 : 0;
        checkOutput({tag, "-ack"}, 3, 0, 1 << g, timedOut, 0);
        mLast = g;
        if (nextReq < 0)
            reqDrive = (reqDrive & ~(3'b001 << g)) |
                       ($urandom_range(0, 1) != 0 ? 3'($urandom_range(0, 7)) : 3'b000);
        else
            reqDrive = nextReq[2:0];
        applyStimulus(reqDrive, 1'b0);
    endtask

    initial begin
        // T1: reset held two cycles with all requests up.
        i_rst = 1'b1;
        applyStimulus(3'b111, 1'b0);
        tick();
        checkOutput("T1-rst0", 3, 0, 0, 0, 0);
        tick();
        checkOutput("T1-rst1", 3, 0, 0, 0, 0);
        i_rst    = 1'b0;
        mLast    = 2;
        reqDrive = 3'b111;

        // T2: all requests held, done two cycles after each start: 0,1,2,0.
        runAccess("T2a", 0, 2, 7);
        runAccess("T2b", 1, 2, 7);
        runAccess("T2c", 2, 2, 7);
        runAccess("T2d", 0, 2, 5);

        // T3: last served was 0, req=101 -> 2 then 0, requester 1 never acked.
        runAccess("T3a", 2, 2, 1);
        runAccess("T3b", 0, 3, 0);

        // Idle with a spurious done pulse: nothing happens.
        applyStimulus(3'b000, 1'b1);
        tick();
        checkOutput("IDLE-done", 3, 0, 0, 0, 0);

        // T4: watchdog abort on the 15th BUSY cycle.
        reqDrive = 3'b010;
        applyStimulus(reqDrive, 1'b0);
        runAccess("T4", 1, 99, 0);
        tick();
        checkOutput("T4-idle", 3, 0, 0, 0, 0);

        // T5: done in the same cycle the watchdog would fire, done wins.
        reqDrive = 3'b010;
        applyStimulus(reqDrive, 1'b0);
        runAccess("T5", 1, TMO, 0);

        // T6: request dropped mid-access has no effect, then reset mid-access.
        applyStimulus(3'b100, 1'b0);
        tick();
        checkOutput("T6-grant", 2, 1, 0, 0, 1);
        applyStimulus(3'b000, 1'b0);
        tick();
        checkOutput("T6-drop", 2, 0, 0, 0, 1);
        i_rst = 1'b1;
        tick();
        checkOutput("T6-rst", 3, 0, 0, 0, 0);
        i_rst = 1'b0;
        applyStimulus(3'b000, 1'b1);
        tick();
        checkOutput("T6-spur", 3, 0, 0, 0, 0);
        applyStimulus(3'b000, 1'b0);
        tick();
        checkOutput("T6-idle", 3, 0, 0, 0, 0);
        mLast    = 2;
        reqDrive = 3'b000;

        // Randomized traffic against the round-robin model.
        for (int i = 0; i < 40; i++) begin
            if (reqDrive == 3'b000) begin
                applyStimulus(3'b000, 1'($urandom_range(0, 1)));
                tick();
                checkOutput("RND-idle", 3, 0, 0, 0, 0);
                reqDrive = 3'($urandom_range(1, 7));
                applyStimulus(reqDrive, 1'b0);
            end
            runAccess("RND", -1, int'($urandom_range(1, 18)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
